// File: rtl/control_multi_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath:
// IR opcode and memory handshake in, every mux select and write enable out.
interface control_multi_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, state
    );
endinterface

// File: rtl/control_multi.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory and single ALU, stretching memory states on mem_ready.
module control_multi #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    control_multi_if.master    bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        BNE    = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       rdy;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       illegal;

    assign rdy = bus.mem_ready | ~WAIT_EN;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Encodings 13-15 fall into the default arm: all outputs low, back to FETCH.
    always_comb begin
        state_d          = FETCH;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_write_cond_ne = 1'b0;
        mem_write        = 1'b0;
        reg_write        = 1'b0;
        ir_write         = 1'b0;
        illegal          = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.ALUOp        = 2'b00;
        bus.PCSource     = 2'b00;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                ir_write    = rdy;
                pc_write    = rdy;
                state_d     = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    6'h00:        state_d = REX;
                    6'h23, 6'h2b: state_d = MEMADR;
                    6'h04:        state_d = BEQ;
                    6'h05:        state_d = BNE;
                    6'h02:        state_d = JUMP;
                    6'h08:        state_d = ADDIEX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.opcode == 6'h2b) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write    = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            // The strobe stays up for the whole wait; memory commits on the rdy cycle.
            MEMWR: begin
                mem_write = 1'b1;
                bus.IorD  = 1'b1;
                state_d   = rdy ? FETCH : MEMWR;
            end
            REX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                bus.RegDst = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUOp     = 2'b01;
                bus.PCSource  = 2'b01;
                pc_write_cond = 1'b1;
            end
            BNE: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUOp        = 2'b01;
                bus.PCSource     = 2'b01;
                pc_write_cond_ne = 1'b1;
            end
            JUMP: begin
                pc_write     = 1'b1;
                bus.PCSource = 2'b10;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // State-changing strobes are masked while reset is held so nothing commits.
    assign bus.PCWrite       = pc_write & ~reset;
    assign bus.PCWriteCond   = pc_write_cond & ~reset;
    assign bus.PCWriteCondNE = pc_write_cond_ne & ~reset;
    assign bus.MemWrite      = mem_write & ~reset;
    assign bus.RegWrite      = reg_write & ~reset;
    assign bus.IRWrite       = ir_write & ~reset;
    assign bus.illegal_op    = illegal & ~reset;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_control_multi.sv
// Directed-vector bench for control_multi: walks every instruction class, wait
// stretching, illegal opcodes and reset-in-wait, plus a WAIT_EN=0 instance.
module tb_control_multi;

    // Output vector order:
    // PCWrite PCWriteCond PCWriteCondNE IorD MemRead MemWrite MemtoReg IRWrite
    // RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
    localparam logic [17:0] O_FETCH_R  = 18'b1_0_0_0_1_0_0_1_0_0_0_01_00_00_0;
    localparam logic [17:0] O_FETCH_W  = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] O_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] O_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [17:0] O_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] O_MEMRD    = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] O_MEMWB    = 18'b0_0_0_0_0_0_1_0_0_1_0_00_00_00_0;
    localparam logic [17:0] O_MEMWR    = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] O_MEMWR_RS = 18'b0_0_0_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] O_REX      = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] O_RWB      = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] O_BEQ      = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] O_BNE      = 18'b0_0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] O_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] O_ADDIWB   = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    control_multi_if bus0 ();
    control_multi_if bus1 ();

    control_multi #(.WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    control_multi #(.WAIT_EN(1'b0)) dut_nowait (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    logic [17:0] obs0;
    logic [17:0] obs1;

    assign obs0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.PCWriteCondNE, bus0.IorD,
                   bus0.MemRead, bus0.MemWrite, bus0.MemtoReg, bus0.IRWrite,
                   bus0.RegDst, bus0.RegWrite, bus0.ALUSrcA, bus0.ALUSrcB,
                   bus0.ALUOp, bus0.PCSource, bus0.illegal_op};
    assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.PCWriteCondNE, bus1.IorD,
                   bus1.MemRead, bus1.MemWrite, bus1.MemtoReg, bus1.IRWrite,
                   bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA, bus1.ALUSrcB,
                   bus1.ALUOp, bus1.PCSource, bus1.illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic rst);
        bus0.opcode    = op;
        bus0.mem_ready = rdy;
        reset          = rst;
    endtask

    task automatic checkOutput(input string tag, input bit sel,
                               input logic [3:0] exp_state, input logic [17:0] exp_out);
        logic [3:0]  got_state;
        logic [17:0] got_out;
        got_state = sel ? bus1.state : bus0.state;
        got_out   = sel ? obs1 : obs0;
        vectors++;
        assert (got_state === exp_state)
        else begin
            miscompares++;
            $error("[TB] FAIL %s state: observed %0d expected %0d", tag, got_state, exp_state);
        end
        vectors++;
        assert (got_out === exp_out)
        else begin
            miscompares++;
            $error("[TB] FAIL %s outputs: observed %b expected %b", tag, got_out, exp_out);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic rdy, input logic rst,
                        input logic [3:0] exp_state, input logic [17:0] exp_out);
        @(negedge clk);
        applyStimulus(op, rdy, rst);
        #1;
        checkOutput(tag, 1'b0, exp_state, exp_out);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus1.opcode    = 6'h23;
        bus1.mem_ready = 1'b0;
        applyStimulus(6'h23, 1'b1, 1'b1);
        @(posedge clk);
        step("reset_hold", 6'h23, 1'b1, 1'b1, 4'd0, O_FETCH_W);

        step("lw_fetch",  6'h23, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("lw_decode", 6'h23, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("lw_memadr", 6'h23, 1'b1, 1'b0, 4'd2, O_MEMADR);
        step("lw_memrd",  6'h23, 1'b1, 1'b0, 4'd3, O_MEMRD);
        step("lw_memwb",  6'h23, 1'b1, 1'b0, 4'd4, O_MEMWB);

        step("sw_fetch",  6'h2b, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("sw_decode", 6'h2b, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("sw_memadr", 6'h2b, 1'b1, 1'b0, 4'd2, O_MEMADR);
        step("sw_wait1",  6'h2b, 1'b0, 1'b0, 4'd5, O_MEMWR);
        step("sw_wait2",  6'h2b, 1'b0, 1'b0, 4'd5, O_MEMWR);
        step("sw_wait3",  6'h2b, 1'b0, 1'b0, 4'd5, O_MEMWR);
        step("sw_commit", 6'h2b, 1'b1, 1'b0, 4'd5, O_MEMWR);

        step("r_fetch",   6'h00, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("r_decode",  6'h00, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("r_rex",     6'h00, 1'b0, 1'b0, 4'd6, O_REX);
        step("r_rwb",     6'h00, 1'b0, 1'b0, 4'd7, O_RWB);

        step("bne_fetch", 6'h05, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("bne_decode",6'h05, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("bne_exec",  6'h05, 1'b1, 1'b0, 4'd9, O_BNE);

        step("fetch_wait1", 6'h04, 1'b0, 1'b0, 4'd0, O_FETCH_W);
        step("fetch_wait2", 6'h04, 1'b0, 1'b0, 4'd0, O_FETCH_W);
        step("fetch_ready", 6'h04, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("beq_decode",  6'h04, 1'b0, 1'b0, 4'd1, O_DECODE);
        step("beq_exec",    6'h04, 1'b0, 1'b0, 4'd8, O_BEQ);

        step("j_fetch",   6'h02, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("j_decode",  6'h02, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("j_exec",    6'h02, 1'b1, 1'b0, 4'd10, O_JUMP);

        step("addi_fetch",  6'h08, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("addi_decode", 6'h08, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("addi_ex",     6'h08, 1'b1, 1'b0, 4'd11, O_MEMADR);
        step("addi_wb",     6'h08, 1'b1, 1'b0, 4'd12, O_ADDIWB);

        step("ill_fetch",  6'h3f, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("ill_decode", 6'h3f, 1'b1, 1'b0, 4'd1, O_DEC_ILL);
        step("ill_return", 6'h3f, 1'b1, 1'b0, 4'd0, O_FETCH_R);

        step("ill_rst_dec", 6'h3f, 1'b1, 1'b1, 4'd1, O_DECODE);
        step("ill_rst_out", 6'h2b, 1'b1, 1'b0, 4'd0, O_FETCH_R);
        step("rsw_decode",  6'h2b, 1'b1, 1'b0, 4'd1, O_DECODE);
        step("rsw_memadr",  6'h2b, 1'b0, 1'b0, 4'd2, O_MEMADR);
        step("rsw_wait",    6'h2b, 1'b0, 1'b0, 4'd5, O_MEMWR);
        step("rsw_reset",   6'h2b, 1'b0, 1'b1, 4'd5, O_MEMWR_RS);
        step("rsw_after",   6'h2b, 1'b0, 1'b0, 4'd0, O_FETCH_W);

        // Restart the WAIT_EN=0 instance from reset; its mem_ready is held low throughout.
        @(negedge clk);
        applyStimulus(6'h00, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(6'h00, 1'b0, 1'b0);
        #1;
        checkOutput("nw_fetch", 1'b1, 4'd0, O_FETCH_R);
        @(negedge clk);
        #1;
        checkOutput("nw_decode", 1'b1, 4'd1, O_DECODE);
        @(negedge clk);
        #1;
        checkOutput("nw_memadr", 1'b1, 4'd2, O_MEMADR);
        @(negedge clk);
        #1;
        checkOutput("nw_memrd", 1'b1, 4'd3, O_MEMRD);
        @(negedge clk);
        #1;
        checkOutput("nw_memwb", 1'b1, 4'd4, O_MEMWB);
        @(negedge clk);
        #1;
        checkOutput("nw_next", 1'b1, 4'd0, O_FETCH_R);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
